// File: rtl/spike_threshold_unit.sv
// spike_threshold_unit
//   Purpose : integrate synaptic weights onto the decayed membrane potential,
//             compare against a threshold, emit a spike, apply post-spike reset
//             and refractory period, and write the new potential back to the
//             decay block with a one-cycle load pulse.
//   Latency : step_end sampled at edge N -> spike/load visible after edge N+1.
//   Backpressure: in_ready is high only in ACCUM; the producer holds a weight
//             otherwise. A decay_valid outside IDLE is dropped and flagged.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_threshold           signed firing threshold (used in FIRE)
//   i_v_reset             signed reset potential (reset_mode 0 / refractory)
//   i_reset_mode          0 = reset to v_reset, 1 = subtract threshold
//   i_refractory_cycles   refractory steps loaded after a spike
//   i_decay_valid         pulse: i_decay_potential valid, opens a step
//   i_decay_potential     decayed membrane potential
//   i_in_valid/o_in_ready weight handshake, i_in_weight = signed weight
//   i_step_end            pulse: no more weights this step
//   o_spike_out           one-cycle spike pulse
//   o_potential_out       new membrane potential, held between writes
//   o_potential_load      one-cycle load pulse to the decay block
//   o_refractory          high while the refractory counter is nonzero
//   o_overrun             sticky: decay_valid arrived while a step was open

module spike_threshold_unit #(
  parameter int REF_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_threshold,
  input  logic signed [DATA_W-1:0] i_v_reset,
  input  logic                     i_reset_mode,
  input  logic [REF_W-1:0]         i_refractory_cycles,
  input  logic                     i_decay_valid,
  input  logic signed [DATA_W-1:0] i_decay_potential,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_in_weight,
  input  logic                     i_step_end,
  output logic                     o_spike_out,
  output logic signed [DATA_W-1:0] o_potential_out,
  output logic                     o_potential_load,
  output logic                     o_refractory,
  output logic                     o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIRE  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Add or subtract in DATA_W+1 bits; the two top bits disagree exactly when
  // the DATA_W-bit result would have wrapped, so clamp toward the sign of
  // the wide result.
  function automatic logic signed [DATA_W-1:0] sat_addsub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sub
  );
    logic signed [DATA_W:0] s;
    if (sub) s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    else     s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      sat_addsub = s[DATA_W] ? SAT_MIN : SAT_MAX;
    else
      sat_addsub = s[DATA_W-1:0];
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [DATA_W-1:0]   r_acc;
  logic [REF_W-1:0]           r_ref_cnt;
  logic                       r_spike;
  logic signed [DATA_W-1:0]   r_pot;
  logic                       r_load;
  logic                       r_overrun;

  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_in_ref;
  logic signed [DATA_W-1:0]   w_sum;
  logic signed [DATA_W-1:0]   w_sub;
  logic                       w_fire;
  logic signed [DATA_W-1:0]   w_new_pot;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state and handshake
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_decay_valid) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (i_step_end) w_state_nxt = S_FIRE;
      end
      S_FIRE:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational terms
  // ---------------------------------------------------------------------------
  always_comb begin
    w_accept  = i_in_valid && w_in_ready;
    w_in_ref  = (r_ref_cnt != '0);
    w_sum     = sat_addsub(r_acc, i_in_weight, 1'b0);
    w_sub     = sat_addsub(r_acc, i_threshold, 1'b1);
    w_fire    = !w_in_ref && (r_acc >= i_threshold);
    w_new_pot = r_acc;
    if (w_fire) w_new_pot = i_reset_mode ? w_sub : i_v_reset;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_ref_cnt <= '0;
      r_spike   <= 1'b0;
      r_pot     <= '0;
      r_load    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A new step may only open from IDLE; anything else is lost data.
      if (i_decay_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // During refractory the decayed value is replaced by v_reset so the
          // neuron sits at rest regardless of what the decay stage produced.
          if (i_decay_valid) r_acc <= w_in_ref ? i_v_reset : i_decay_potential;
        end
        S_ACCUM: begin
          // Refractory steps still drain weights so the producer never stalls.
          if (w_accept && !w_in_ref) r_acc <= w_sum;
        end
        S_FIRE: begin
          r_pot   <= w_new_pot;
          r_spike <= w_fire;
          r_load  <= 1'b1;
          if (w_fire)        r_ref_cnt <= i_refractory_cycles;
          else if (w_in_ref) r_ref_cnt <= r_ref_cnt - 1'b1;
        end
        S_WRITE: begin
          // Dropping load here guarantees a low IDLE cycle before the next
          // write, so the decay block always sees a fresh rising edge.
          r_spike <= 1'b0;
          r_load  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready       = w_in_ready;
  assign o_spike_out      = r_spike;
  assign o_potential_out  = r_pot;
  assign o_potential_load = r_load;
  assign o_refractory     = (r_ref_cnt != '0);
  assign o_overrun        = r_overrun;

endmodule
